// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and FSM state type for req_encoder8
package enc_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/req_encoder8_if.sv
// rtl/req_encoder8_if.sv - request capture and index handshake bundle
interface req_encoder8_if;

  logic                      en;
  logic [enc_pkg::N-1:0]     req;
  logic                      ready;
  logic                      valid;
  logic [enc_pkg::IDX_W-1:0] idx;
  logic [enc_pkg::N-1:0]     pending;
  logic                      overflow;
  logic                      busy;

  modport master (
    input  en, req, ready,
    output valid, idx, pending, overflow, busy
  );

  modport slave (
    output en, req, ready,
    input  valid, idx, pending, overflow, busy
  );

endinterface

// File: rtl/pri_enc8to3.sv
// rtl/pri_enc8to3.sv - combinational 8-to-3 priority encoder, bit 7 highest
module pri_enc8to3
  import enc_pkg::*;
(
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/req_encoder8.sv
// rtl/req_encoder8.sv - buffered priority encoder draining pending requests as an index stream
module req_encoder8
  import enc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  req_encoder8_if.master  bus
);

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     pending_q;
  logic [N-1:0]     pending_next;
  logic [N-1:0]     served;
  logic [N-1:0]     req_g;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             overflow_q;
  logic             busy_q;
  logic             valid;
  logic             load;

  always_comb begin
    served       = (valid && bus.ready) ? (N'(1) << idx_q) : '0;
    req_g        = bus.en ? bus.req : '0;
    cand         = pending_q & ~served;
    // A bit set in the same cycle it is served survives as a fresh request.
    pending_next = cand | req_g;
  end

  pri_enc8to3 u_pri (
    .vec (cand),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = enc_any ? HOLD : IDLE;
    end
  end

  // A held index is never preempted; it only moves on acceptance.
  always_comb begin
    valid = (state == HOLD);
    load  = (state == IDLE) || bus.ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      pending_q  <= pending_next;
      busy_q     <= |pending_next;
      overflow_q <= |(req_g & cand);
      if (load && enc_any) begin
        idx_q <= enc_idx;
      end
    end
  end

  assign bus.valid    = valid;
  assign bus.idx      = idx_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;

endmodule
